// File: rtl/csr_cntr_pkg.sv
// Shared CSR addresses and helpers for the machine counter bank.
// Counter slot k maps to CSR offset 0 (mcycle), 2 (minstret) or k+1 (mhpmcounter).
package csr_cntr_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

    typedef enum logic [1:0] {
        BANK_NONE,
        BANK_LO,
        BANK_HI
    } cntr_bank_e;

    function automatic cntr_bank_e decode_bank(input logic [11:0] addr);
        case (addr[11:5])
            CSR_MCYCLE[11:5], CSR_CYCLE[11:5]:   return BANK_LO;
            CSR_MCYCLEH[11:5], CSR_CYCLEH[11:5]: return BANK_HI;
            default:                             return BANK_NONE;
        endcase
    endfunction

    function automatic logic [4:0] cnt_off(input int k);
        return (k == 0) ? 5'd0 : 5'(k + 1);
    endfunction

    // Implemented counter bits: CY, IR and one bit per mhpmcounter (TM excluded).
    function automatic logic [31:0] cnt_mask(input int hpm_num);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int i = 0; i < hpm_num; i++) begin
            m[3+i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/csr_cntr64.sv
// One 64-bit machine counter; a write to either half wins over that cycle's increment.
module csr_cntr64 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_lo,
    input  logic            wr_hi,
    input  logic [XLEN-1:0] wdata,
    input  logic            inc,
    input  logic            inhibit,
    output logic [63:0]     cnt
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (XLEN == 64) begin
            if (wr_lo) begin
                cnt_d = 64'(wdata);
            end
        end else begin
            if (wr_lo) begin
                cnt_d = {cnt_q[63:32], 32'(wdata)};
            end else if (wr_hi) begin
                cnt_d = {32'(wdata), cnt_q[31:0]};
            end
        end
        if (!wr_lo && !wr_hi && inc && !inhibit) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/csr_cntr.sv
// Machine counter CSR bank: address decode, set/clear write merge, inhibit/enable
// registers and the combinational read mux over mcycle, minstret and mhpmcounters.
module csr_cntr
    import csr_cntr_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int HPM_NUM = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_wr,
    input  logic [11:0]        csr_waddr,
    input  logic [XLEN-1:0]    csr_stb,
    input  logic [XLEN-1:0]    csr_clr,
    input  logic [11:0]        csr_raddr,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_hit,
    input  logic               inst_ret,
    input  logic [HPM_NUM-1:0] hpm_evt,
    output logic [31:0]        mcounteren_o
);

    localparam int          NCNT     = 2 + HPM_NUM;
    localparam logic [31:0] INH_MASK = cnt_mask(HPM_NUM);
    localparam logic [31:0] EN_MASK  = cnt_mask(HPM_NUM) | 32'h0000_0002;

    logic [31:0]     mcountinhibit_q;
    logic [31:0]     mcountinhibit_d;
    logic [31:0]     mcounteren_q;
    logic [31:0]     mcounteren_d;
    logic [63:0]     cnt [NCNT];
    logic [NCNT-1:0] inc_vec;
    cntr_bank_e      bank;

    assign inc_vec = {hpm_evt, inst_ret, 1'b1};

    always_comb begin
        mcountinhibit_d = mcountinhibit_q;
        mcounteren_d    = mcounteren_q;
        if (csr_wr && csr_waddr == CSR_MCOUNTINHIBIT) begin
            mcountinhibit_d = 32'((XLEN'(mcountinhibit_q) & ~csr_clr) | csr_stb) & INH_MASK;
        end
        if (csr_wr && csr_waddr == CSR_MCOUNTEREN) begin
            mcounteren_d = 32'((XLEN'(mcounteren_q) & ~csr_clr) | csr_stb) & EN_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcountinhibit_q <= '0;
            mcounteren_q    <= '0;
        end else begin
            mcountinhibit_q <= mcountinhibit_d;
            mcounteren_q    <= mcounteren_d;
        end
    end

    // Only M-mode addresses write; user shadows and unimplemented slots never match here.
    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        localparam logic [4:0] OFF = cnt_off(k);

        logic            wr_lo;
        logic            wr_hi;
        logic [XLEN-1:0] old_half;
        logic [XLEN-1:0] wdata;

        assign wr_lo    = csr_wr && (csr_waddr == (CSR_MCYCLE | 12'(OFF)));
        assign wr_hi    = (XLEN == 32) && csr_wr && (csr_waddr == (CSR_MCYCLEH | 12'(OFF)));
        assign old_half = wr_hi ? XLEN'(cnt[k][63:32]) : XLEN'(cnt[k]);
        assign wdata    = (old_half & ~csr_clr) | csr_stb;

        csr_cntr64 #(
            .XLEN(XLEN)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .wr_lo  (wr_lo),
            .wr_hi  (wr_hi),
            .wdata  (wdata),
            .inc    (inc_vec[k]),
            .inhibit(mcountinhibit_q[OFF]),
            .cnt    (cnt[k])
        );
    end

    // Offset 1 is the time CSR, served elsewhere; other unused slots read as zero.
    always_comb begin
        csr_rdata = '0;
        csr_hit   = 1'b0;
        bank      = decode_bank(csr_raddr);
        if (csr_raddr == CSR_MCOUNTINHIBIT) begin
            csr_hit   = 1'b1;
            csr_rdata = XLEN'(mcountinhibit_q);
        end else if (csr_raddr == CSR_MCOUNTEREN) begin
            csr_hit   = 1'b1;
            csr_rdata = XLEN'(mcounteren_q);
        end else if (bank != BANK_NONE && csr_raddr[4:0] != 5'd1 &&
                     !(XLEN == 64 && bank == BANK_HI)) begin
            csr_hit = 1'b1;
            for (int k = 0; k < NCNT; k++) begin
                if (csr_raddr[4:0] == cnt_off(k)) begin
                    csr_rdata = (bank == BANK_HI) ? XLEN'(cnt[k][63:32]) : XLEN'(cnt[k]);
                end
            end
        end
    end

    assign mcounteren_o = mcounteren_q;

endmodule

// File: tb/tb_csr_cntr.sv
// Directed self-checking bench for csr_cntr (XLEN=32, HPM_NUM=2).
module tb_csr_cntr;

    logic        clk;
    logic        rst;
    logic        csr_wr;
    logic [11:0] csr_waddr;
    logic [31:0] csr_stb;
    logic [31:0] csr_clr;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        inst_ret;
    logic [1:0]  hpm_evt;
    logic [31:0] mcounteren_o;

    int checks = 0;
    int errors = 0;

    csr_cntr #(
        .XLEN   (32),
        .HPM_NUM(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_wr      (csr_wr),
        .csr_waddr   (csr_waddr),
        .csr_stb     (csr_stb),
        .csr_clr     (csr_clr),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .csr_hit     (csr_hit),
        .inst_ret    (inst_ret),
        .hpm_evt     (hpm_evt),
        .mcounteren_o(mcounteren_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] stb, input logic [31:0] clr);
        csr_wr    = 1'b1;
        csr_waddr = addr;
        csr_stb   = stb;
        csr_clr   = clr;
        tick();
        csr_wr  = 1'b0;
        csr_stb = '0;
        csr_clr = '0;
    endtask

    task automatic rd(input logic [11:0] addr);
        csr_raddr = addr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rd(12'hB00);
        checks++;
        if (csr_rdata !== 32'd0 || csr_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mcycle: got %h hit %b expected 0 hit 1", csr_rdata, csr_hit);
        end
        rd(12'h320);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_inhibit: got %h expected 0", csr_rdata);
        end
        checks++;
        if (mcounteren_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_mcounteren: got %h expected 0", mcounteren_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rd(12'hB00);
        checks++;
        if (csr_rdata !== 32'd10) begin
            errors++;
            $display("[TB] FAIL idle_mcycle_lo: got %h expected %h", csr_rdata, 32'd10);
        end
        rd(12'hB80);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL idle_mcycle_hi: got %h expected 0", csr_rdata);
        end
        rd(12'hB02);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL idle_minstret: got %h expected 0", csr_rdata);
        end
    endtask

    task automatic test_carry();
        csr_write(12'hB80, 32'h0, 32'hFFFF_FFFF);
        csr_write(12'hB00, 32'hFFFF_FFFF, 32'h0);
        rd(12'hB00);
        checks++;
        if (csr_rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL carry_pre_lo: got %h expected ffffffff", csr_rdata);
        end
        tick();
        rd(12'hB00);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL carry_lo: got %h expected 0", csr_rdata);
        end
        rd(12'hB80);
        checks++;
        if (csr_rdata !== 32'd1) begin
            errors++;
            $display("[TB] FAIL carry_hi: got %h expected 1", csr_rdata);
        end
    endtask

    task automatic test_wrap();
        csr_write(12'hB80, 32'hFFFF_FFFF, 32'h0);
        csr_write(12'hB00, 32'hFFFF_FFFF, 32'h0);
        rd(12'hB80);
        checks++;
        if (csr_rdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL wrap_pre_hi: got %h expected ffffffff", csr_rdata);
        end
        tick();
        rd(12'hB00);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL wrap_lo: got %h expected 0", csr_rdata);
        end
        rd(12'hB80);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL wrap_hi: got %h expected 0", csr_rdata);
        end
    endtask

    task automatic test_hpm();
        hpm_evt = 2'b01;
        for (int i = 0; i < 3; i++) tick();
        hpm_evt = 2'b00;
        rd(12'hB03);
        checks++;
        if (csr_rdata !== 32'd3) begin
            errors++;
            $display("[TB] FAIL hpm3_count: got %h expected 3", csr_rdata);
        end
        rd(12'hB04);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL hpm4_idle: got %h expected 0", csr_rdata);
        end
        rd(12'hC03);
        checks++;
        if (csr_rdata !== 32'd3) begin
            errors++;
            $display("[TB] FAIL hpm3_shadow: got %h expected 3", csr_rdata);
        end
        hpm_evt = 2'b10;
        tick();
        hpm_evt = 2'b00;
        rd(12'hB04);
        checks++;
        if (csr_rdata !== 32'd1) begin
            errors++;
            $display("[TB] FAIL hpm4_count: got %h expected 1", csr_rdata);
        end
    endtask

    task automatic test_write_priority();
        inst_ret = 1'b1;
        csr_write(12'hB02, 32'h5, ~32'h5);
        rd(12'hB02);
        checks++;
        if (csr_rdata !== 32'd5) begin
            errors++;
            $display("[TB] FAIL wr_beats_inc: got %h expected 5", csr_rdata);
        end
        tick();
        inst_ret = 1'b0;
        rd(12'hB02);
        checks++;
        if (csr_rdata !== 32'd6) begin
            errors++;
            $display("[TB] FAIL inc_after_wr: got %h expected 6", csr_rdata);
        end
        csr_wr    = 1'b1;
        csr_waddr = 12'hB02;
        csr_stb   = 32'h9;
        csr_clr   = ~32'h9;
        rd(12'hB02);
        checks++;
        if (csr_rdata !== 32'd6) begin
            errors++;
            $display("[TB] FAIL read_pre_update: got %h expected 6", csr_rdata);
        end
        tick();
        csr_wr  = 1'b0;
        csr_stb = '0;
        csr_clr = '0;
        rd(12'hB02);
        checks++;
        if (csr_rdata !== 32'd9) begin
            errors++;
            $display("[TB] FAIL read_post_update: got %h expected 9", csr_rdata);
        end
    endtask

    task automatic test_inhibit();
        csr_write(12'hB00, 32'd100, ~32'd100);
        inst_ret = 1'b1;
        csr_write(12'h320, 32'h5, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        inst_ret = 1'b0;
        rd(12'h320);
        checks++;
        if (csr_rdata !== 32'h5) begin
            errors++;
            $display("[TB] FAIL inhibit_read: got %h expected 5", csr_rdata);
        end
        rd(12'hB00);
        checks++;
        if (csr_rdata !== 32'd101) begin
            errors++;
            $display("[TB] FAIL inhibit_mcycle: got %h expected %h", csr_rdata, 32'd101);
        end
        rd(12'hB02);
        checks++;
        if (csr_rdata !== 32'd10) begin
            errors++;
            $display("[TB] FAIL inhibit_minstret: got %h expected %h", csr_rdata, 32'd10);
        end
    endtask

    task automatic test_masks();
        csr_write(12'h320, 32'h0, 32'hFFFF_FFFF);
        csr_write(12'h320, 32'h2, 32'h0);
        rd(12'h320);
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL inhibit_tm_zero: got %h expected 0", csr_rdata);
        end
        csr_write(12'h320, 32'hFFFF_FFFF, 32'h0);
        rd(12'h320);
        checks++;
        if (csr_rdata !== 32'h1D) begin
            errors++;
            $display("[TB] FAIL inhibit_mask: got %h expected 1d", csr_rdata);
        end
        csr_write(12'h320, 32'h0, 32'hFFFF_FFFF);
        csr_write(12'h306, 32'hFFFF_FFFF, 32'h0);
        rd(12'h306);
        checks++;
        if (csr_rdata !== 32'h1F || mcounteren_o !== 32'h1F) begin
            errors++;
            $display("[TB] FAIL mcounteren_mask: got %h port %h expected 1f", csr_rdata, mcounteren_o);
        end
        csr_write(12'h306, 32'h2, ~32'h2);
        checks++;
        if (mcounteren_o !== 32'h2) begin
            errors++;
            $display("[TB] FAIL mcounteren_plain: got %h expected 2", mcounteren_o);
        end
    endtask

    task automatic test_shadow();
        csr_write(12'hB00, 32'd50, ~32'd50);
        csr_write(12'hC00, 32'h0, 32'hFFFF_FFFF);
        rd(12'hB00);
        checks++;
        if (csr_rdata !== 32'd51) begin
            errors++;
            $display("[TB] FAIL shadow_wr_ignored: got %h expected %h", csr_rdata, 32'd51);
        end
        rd(12'hC00);
        checks++;
        if (csr_rdata !== 32'd51 || csr_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL shadow_mirror: got %h hit %b expected %h hit 1", csr_rdata, csr_hit, 32'd51);
        end
        rd(12'hC80);
        checks++;
        if (csr_rdata !== 32'd0 || csr_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL shadow_hi: got %h hit %b expected 0 hit 1", csr_rdata, csr_hit);
        end
    endtask

    task automatic test_unimpl();
        rd(12'hB05);
        checks++;
        if (csr_rdata !== 32'd0 || csr_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unimpl_b05: got %h hit %b expected 0 hit 1", csr_rdata, csr_hit);
        end
        rd(12'hB9F);
        checks++;
        if (csr_rdata !== 32'd0 || csr_hit !== 1'b1) begin
            errors++;
            $display("[TB] FAIL unimpl_b9f: got %h hit %b expected 0 hit 1", csr_rdata, csr_hit);
        end
        rd(12'h123);
        checks++;
        if (csr_rdata !== 32'd0 || csr_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nohit_123: got %h hit %b expected 0 hit 0", csr_rdata, csr_hit);
        end
        rd(12'hB01);
        checks++;
        if (csr_hit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nohit_b01: got hit %b expected 0", csr_hit);
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rd(12'hB00);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_mcycle: got %h expected 0", csr_rdata);
        end
        rd(12'hB02);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_minstret: got %h expected 0", csr_rdata);
        end
        rd(12'hB03);
        checks++;
        if (csr_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_hpm3: got %h expected 0", csr_rdata);
        end
        checks++;
        if (mcounteren_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rst_mid_mcounteren: got %h expected 0", mcounteren_o);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        csr_wr    = 1'b0;
        csr_waddr = '0;
        csr_stb   = '0;
        csr_clr   = '0;
        csr_raddr = '0;
        inst_ret  = 1'b0;
        hpm_evt   = '0;
        test_reset();
        test_carry();
        test_wrap();
        test_hpm();
        test_write_priority();
        test_inhibit();
        test_masks();
        test_shadow();
        test_unimpl();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
